// File: rtl/trace_pkg.sv
// trace_pkg: shared constants, FSM encoding and the packet-count helper for the
// trace read-back path (trace_reader and its read FIFO).
package trace_pkg;

   localparam int SAMPLE_PACKET_WIDTH = 32;
   localparam int ADDR_WIDTH          = 16;
   localparam int MEM_LATENCY         = 2;
   localparam int BYTES_PER_PACKET    = SAMPLE_PACKET_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } traceState_t;

   // Inclusive packet count; an inverted range means nothing to read.
   function automatic logic [31:0] packetCount(input logic [31:0] firstNum,
                                               input logic [31:0] lastNum);
      logic [31:0] n;
      if (lastNum < firstNum) begin
         n = 32'd0;
      end else begin
         n = lastNum - firstNum + 32'd1;
      end
      return n;
   endfunction

endpackage

// File: rtl/trace_rd_fifo.sv
// trace_rd_fifo: small synchronous FIFO holding packets returned by the trace RAM
// until the serializer takes them.
// Ports: clk/reset (async active-low), flush (drop contents), push/pushData,
//        pop/popData (head word, valid while count != 0), count (occupancy).
module trace_rd_fifo
   import trace_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 3,
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] pushData,
   input  logic             pop,
   output logic [WIDTH-1:0] popData,
   output logic [CNT_W-1:0] count
);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wrPtr_r;
   logic [PTR_W-1:0] rdPtr_r;
   logic [CNT_W-1:0] count_r;
   logic             wrEn_s;
   logic             rdEn_s;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] n;
      if (p == PTR_W'(DEPTH - 1)) begin
         n = '0;
      end else begin
         n = p + PTR_W'(1);
      end
      return n;
   endfunction

   // Qualify push/pop against occupancy; a push into a full FIFO is accepted only alongside a pop.
   always_comb begin
      rdEn_s = pop && (count_r != CNT_W'(0));
      wrEn_s = push && ((count_r != CNT_W'(DEPTH)) || rdEn_s);
   end

   // Storage, pointers and occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wrPtr_r <= '0;
         rdPtr_r <= '0;
         count_r <= '0;
      end else if (flush) begin
         wrPtr_r <= '0;
         rdPtr_r <= '0;
         count_r <= '0;
      end else begin
         if (wrEn_s) begin
            mem_r[wrPtr_r] <= pushData;
            wrPtr_r        <= nextPtr(wrPtr_r);
         end
         if (rdEn_s) begin
            rdPtr_r <= nextPtr(rdPtr_r);
         end
         case ({wrEn_s, rdEn_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign popData = mem_r[rdPtr_r];
   assign count   = count_r;

endmodule

// File: rtl/trace_reader.sv
// trace_reader: walks packet numbers Begin..End, reads each packet from the trace
// RAM and streams it out LSB byte first on a valid/ready byte interface.
// Ports: clk/reset (async active-low); start/abort control; sampleNumber_Begin/End
//        range (latched on start); mem_rd_en/addr/data RAM read port (fixed
//        MEM_LATENCY); byte_data/valid/ready output stream; busy, done, bytes_sent status.
module trace_reader
   import trace_pkg::*;
#(
   parameter int SAMPLE_PACKET_WIDTH = trace_pkg::SAMPLE_PACKET_WIDTH,
   parameter int ADDR_WIDTH          = trace_pkg::ADDR_WIDTH,
   parameter int MEM_LATENCY         = trace_pkg::MEM_LATENCY
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           abort,
   input  logic [31:0]                    sampleNumber_Begin,
   input  logic [31:0]                    sampleNumber_End,
   output logic                           mem_rd_en,
   output logic [ADDR_WIDTH-1:0]          mem_rd_addr,
   input  logic [SAMPLE_PACKET_WIDTH-1:0] mem_rd_data,
   output logic [7:0]                     byte_data,
   output logic                           byte_valid,
   input  logic                           byte_ready,
   output logic                           busy,
   output logic                           done,
   output logic [31:0]                    bytes_sent
);

   localparam int PKT_BYTES = SAMPLE_PACKET_WIDTH / 8;
   localparam int DEPTH     = MEM_LATENCY + 1;
   localparam int CNT_W     = $clog2(DEPTH + 1);
   localparam int IDX_W     = (PKT_BYTES > 1) ? $clog2(PKT_BYTES) : 1;
   localparam int OUT_W     = $clog2(DEPTH + MEM_LATENCY + 2) + 1;

   traceState_t                    state_r;
   traceState_t                    nextState_s;
   logic                           rdEn_r;
   logic [ADDR_WIDTH-1:0]          addr_r;
   logic [31:0]                    readsLeft_r;   // reads not yet scheduled
   logic [31:0]                    pktLeft_r;     // packets not yet fully accepted
   logic [MEM_LATENCY-1:0]         dly_r;         // rd_en delayed to data-return time
   logic [SAMPLE_PACKET_WIDTH-1:0] shReg_r;
   logic [IDX_W-1:0]               byteIdx_r;
   logic                           byteValid_r;
   logic                           busy_r;
   logic                           done_r;
   logic [31:0]                    bytesSent_r;

   logic [SAMPLE_PACKET_WIDTH-1:0] fifoData_s;
   logic [SAMPLE_PACKET_WIDTH-1:0] loadData_s;
   logic [CNT_W-1:0]               fifoCount_s;
   logic [31:0]                    reqCount_s;
   logic [OUT_W-1:0]               outstanding_s;
   logic accept_s, lastByte_s, pktDone_s, pushValid_s, fifoEmpty_s;
   logic doLoad_s, fifoPush_s, fifoPop_s, lastRead_s, issueNext_s, startAcc_s;

   // Handshake, serializer load and read-credit decisions for this cycle.
   always_comb begin
      reqCount_s  = packetCount(sampleNumber_Begin, sampleNumber_End);
      startAcc_s  = (state_r == IDLE) && start && !abort;
      accept_s    = byteValid_r && byte_ready;
      lastByte_s  = (byteIdx_r == IDX_W'(PKT_BYTES - 1));
      pktDone_s   = accept_s && lastByte_s;
      pushValid_s = dly_r[MEM_LATENCY-1];
      fifoEmpty_s = (fifoCount_s == CNT_W'(0));
      // Returning data bypasses an empty FIFO so the first byte is not delayed a cycle.
      doLoad_s    = (!byteValid_r || pktDone_s) && (!fifoEmpty_s || pushValid_s) && !abort;
      fifoPush_s  = pushValid_s && !(doLoad_s && fifoEmpty_s);
      fifoPop_s   = doLoad_s && !fifoEmpty_s;
      loadData_s  = fifoEmpty_s ? mem_rd_data : fifoData_s;
      lastRead_s  = rdEn_r && (readsLeft_r == 32'd0);
      // Conservative credit: everything queued or in flight, counted before this cycle's pops.
      outstanding_s = OUT_W'(fifoCount_s) + OUT_W'(rdEn_r);
      for (int i = 0; i < MEM_LATENCY; i++) begin
         outstanding_s = outstanding_s + OUT_W'(dly_r[i]);
      end
   end

   // Next-state selection; abort overrides every other event.
   always_comb begin
      nextState_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               nextState_s = (reqCount_s != 32'd0) ? FETCH : DONE;
            end else begin
               nextState_s = IDLE;
            end
         end
         FETCH:   nextState_s = lastRead_s ? DRAIN : FETCH;
         DRAIN:   nextState_s = (pktDone_s && (pktLeft_r == 32'd1)) ? DONE : DRAIN;
         DONE:    nextState_s = IDLE;
         default: nextState_s = IDLE;
      endcase
      if (abort) begin
         nextState_s = IDLE;
      end else begin
         nextState_s = nextState_s;
      end
      issueNext_s = (nextState_s == FETCH) && (readsLeft_r != 32'd0) &&
                    (outstanding_s < OUT_W'(DEPTH));
   end

   // FSM, read issue, latency delay line, serializer and status registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         rdEn_r      <= 1'b0;
         addr_r      <= '0;
         readsLeft_r <= 32'd0;
         pktLeft_r   <= 32'd0;
         dly_r       <= '0;
         shReg_r     <= '0;
         byteIdx_r   <= '0;
         byteValid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         bytesSent_r <= 32'd0;
      end else if (abort) begin
         state_r     <= IDLE;
         rdEn_r      <= 1'b0;
         dly_r       <= '0;
         byteValid_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r <= nextState_s;
         busy_r  <= (nextState_s == FETCH) || (nextState_s == DRAIN);
         done_r  <= (state_r == DONE);
         dly_r   <= (dly_r << 1) | MEM_LATENCY'(rdEn_r);

         if (startAcc_s) begin
            addr_r      <= sampleNumber_Begin[ADDR_WIDTH-1:0];
            rdEn_r      <= (reqCount_s != 32'd0);
            readsLeft_r <= (reqCount_s != 32'd0) ? (reqCount_s - 32'd1) : 32'd0;
            pktLeft_r   <= reqCount_s;
            bytesSent_r <= 32'd0;
         end else begin
            rdEn_r <= issueNext_s;
            if (issueNext_s) begin
               readsLeft_r <= readsLeft_r - 32'd1;
            end
            if (rdEn_r) begin
               addr_r <= addr_r + ADDR_WIDTH'(1);
            end
            if (accept_s) begin
               bytesSent_r <= bytesSent_r + 32'd1;
            end
            if (pktDone_s) begin
               pktLeft_r <= pktLeft_r - 32'd1;
            end
         end

         if (doLoad_s) begin
            shReg_r     <= loadData_s;
            byteIdx_r   <= '0;
            byteValid_r <= 1'b1;
         end else if (accept_s) begin
            if (lastByte_s) begin
               byteValid_r <= 1'b0;
            end else begin
               shReg_r   <= shReg_r >> 8;
               byteIdx_r <= byteIdx_r + IDX_W'(1);
            end
         end
      end
   end

   trace_rd_fifo #(
      .WIDTH (SAMPLE_PACKET_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .flush    (abort),
      .push     (fifoPush_s),
      .pushData (mem_rd_data),
      .pop      (fifoPop_s),
      .popData  (fifoData_s),
      .count    (fifoCount_s)
   );

   assign mem_rd_en   = rdEn_r;
   assign mem_rd_addr = addr_r;
   assign byte_data   = shReg_r[7:0];
   assign byte_valid  = byteValid_r;
   assign busy        = busy_r;
   assign done        = done_r;
   assign bytes_sent  = bytesSent_r;

endmodule
